key_pulse_gen: RTL and testbench

//  Converts the five decoded PS/2 key levels (W/S/A/D/ENTER, from key_down of Keyboard_Decoder)

---
 rtl/key_pulse_gen.sv | 181 ++++++++++++++++++
 tb/tb_key_pulse_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/key_pulse_gen.sv
// key_pulse_gen
//   Turns the five decoded key levels {ENTER,RIGHT,LEFT,DOWN,UP} into clean
//   one-cycle command pulses. It detects edges, lets only one key win per cycle,
//   and auto-repeats direction keys while they are held.
//
// Parameters
//   HOLD_CYCLES    cycles a repeating key must be held before its first repeat pulse
//   REPEAT_CYCLES  cycles between later repeat pulses (must not exceed HOLD_CYCLES)
//   REPEAT_MASK    per-key repeat enable, bit order {ENTER,RIGHT,LEFT,DOWN,UP}
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-low
//   en          1 = generate pulses; 0 = suppress pulses and hold the FSM in IDLE
//   key_level   raw held key levels, already in the clk domain
//   key_pulse   registered one-hot (or zero) command pulse, one cycle wide
//   key_held    registered copy of key_level
//   active_key  index 0-4 of the key that owns the repeat timer, 7 when none
module key_pulse_gen #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter logic [4:0]  REPEAT_MASK   = 5'b01111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] key_level,
  output logic [4:0] key_pulse,
  output logic [4:0] key_held,
  output logic [2:0] active_key
);

  localparam int unsigned NKEYS = 5;
  localparam int unsigned IDXW  = 3;
  localparam int unsigned CW    = $clog2(HOLD_CYCLES + 1);

  localparam logic [IDXW-1:0] NO_KEY    = IDXW'(7);
  localparam logic [IDXW-1:0] IDX_UP    = IDXW'(0);
  localparam logic [IDXW-1:0] IDX_DOWN  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LEFT  = IDXW'(2);
  localparam logic [IDXW-1:0] IDX_RIGHT = IDXW'(3);
  localparam logic [IDXW-1:0] IDX_ENTER = IDXW'(4);

  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LOAD = CW'(REPEAT_CYCLES - 1);

  // ENTER is a confirm key; it never repeats, whatever the mask says.
  localparam logic [NKEYS-1:0] REPEAT_EN = REPEAT_MASK & NKEYS'(5'b01111);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  // Cleared by reset, set after the first edge: keys held through reset
  // release must not look like fresh presses.
  logic             armed;

  logic [NKEYS-1:0] rise;
  logic [NKEYS-1:0] active_onehot;
  logic [NKEYS-1:0] cand;
  logic             win_any;
  logic [IDXW-1:0]  win_idx;
  logic [NKEYS-1:0] win_onehot;
  logic             active_released;

  // Rising edges of the key levels against the previous sample.
  always_comb begin
    rise = '0;
    if (armed) begin
      rise = key_level & ~key_held;
    end
  end

  // One-hot of the key that owns the timer. It is zero when no key owns it.
  always_comb begin
    active_onehot = '0;
    case (active_key)
      IDX_UP:    active_onehot = NKEYS'(5'b00001);
      IDX_DOWN:  active_onehot = NKEYS'(5'b00010);
      IDX_LEFT:  active_onehot = NKEYS'(5'b00100);
      IDX_RIGHT: active_onehot = NKEYS'(5'b01000);
      IDX_ENTER: active_onehot = NKEYS'(5'b10000);
      default:   active_onehot = '0;
    endcase
  end

  // The active key is held by definition, so it cannot rise. Masking it here
  // also keeps "new rise on another key" honest.
  always_comb begin
    cand            = rise & ~active_onehot;
    active_released = (key_level & active_onehot) == '0;
  end

  // Priority ENTER > UP > DOWN > LEFT > RIGHT. Losing rises are dropped.
  always_comb begin
    win_any    = |cand;
    win_idx    = IDX_UP;
    win_onehot = '0;
    if (cand[IDX_ENTER]) begin
      win_idx    = IDX_ENTER;
      win_onehot = NKEYS'(5'b10000);
    end else if (cand[IDX_UP]) begin
      win_idx    = IDX_UP;
      win_onehot = NKEYS'(5'b00001);
    end else if (cand[IDX_DOWN]) begin
      win_idx    = IDX_DOWN;
      win_onehot = NKEYS'(5'b00010);
    end else if (cand[IDX_LEFT]) begin
      win_idx    = IDX_LEFT;
      win_onehot = NKEYS'(5'b00100);
    end else if (cand[IDX_RIGHT]) begin
      win_idx    = IDX_RIGHT;
      win_onehot = NKEYS'(5'b01000);
    end
  end

  // Input stage, arbitration and hold/repeat FSM. All outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      armed      <= 1'b0;
      key_held   <= '0;
      key_pulse  <= '0;
      active_key <= NO_KEY;
    end else begin
      key_held  <= key_level;
      armed     <= 1'b1;
      key_pulse <= '0;

      if (!en) begin
        state      <= IDLE;
        cnt        <= '0;
        active_key <= NO_KEY;
      end else if (win_any) begin
        // A fresh press beats release and timer expiry. It restarts as if from IDLE.
        key_pulse <= win_onehot;
        if (REPEAT_EN[win_idx]) begin
          state      <= HOLD;
          cnt        <= HOLD_LOAD;
          active_key <= win_idx;
        end else begin
          state      <= IDLE;
          cnt        <= '0;
          active_key <= NO_KEY;
        end
      end else begin
        case (state)
          IDLE: begin
            cnt        <= '0;
            active_key <= NO_KEY;
          end
          HOLD, REPEAT: begin
            if (active_released) begin
              // Release beats expiry. No pulse is sent in this cycle.
              state      <= IDLE;
              cnt        <= '0;
              active_key <= NO_KEY;
            end else if (cnt == '0) begin
              key_pulse <= active_onehot;
              cnt       <= REPEAT_LOAD;
              state     <= REPEAT;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: begin
            state      <= IDLE;
            cnt        <= '0;
            active_key <= NO_KEY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Testbench for key_pulse_gen with HOLD_CYCLES=10 and REPEAT_CYCLES=4.
// Each scenario pushes its expected pulses, as absolute cycle and value, into
// a scoreboard. A negedge monitor pops an entry when its cycle arrives. In
// every other cycle the monitor requires key_pulse to be zero.
module tb_key_pulse_gen;

  localparam int unsigned HOLD = 10;
  localparam int unsigned REP  = 4;

  localparam logic [4:0] K_UP    = 5'b00001;
  localparam logic [4:0] K_DOWN  = 5'b00010;
  localparam logic [4:0] K_LEFT  = 5'b00100;
  localparam logic [4:0] K_RIGHT = 5'b01000;
  localparam logic [4:0] K_ENTER = 5'b10000;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] key_level;
  logic [4:0] key_pulse;
  logic [4:0] key_held;
  logic [2:0] active_key;

  typedef struct {
    int         at;
    logic [4:0] pulse;
  } exp_t;

  exp_t sb[$];
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   base;

  key_pulse_gen #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .REPEAT_MASK  (5'b01111)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .key_level (key_level),
    .key_pulse (key_pulse),
    .key_held  (key_held),
    .active_key(active_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // rel is the offset from the first pulse. That pulse shows up after the next edge.
  task automatic expect_at(input int b, input int rel, input logic [4:0] p);
    exp_t e;
    e.at    = b + rel;
    e.pulse = p;
    sb.push_back(e);
  endtask

  // Monitor: compare at negedge, away from the active edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() != 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      check_eq("missed_pulse_cycle", 32'(cyc), 32'(e.at));
    end
    if (sb.size() != 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      check_eq("pulse", 32'(key_pulse), 32'(e.pulse));
    end else begin
      check_eq("no_pulse", 32'(key_pulse), 32'd0);
    end
  end

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    key_level = '0;

    // Reset state.
    tick(1);
    check_eq("rst_pulse", 32'(key_pulse), 32'd0);
    check_eq("rst_held", 32'(key_held), 32'd0);
    check_eq("rst_active", 32'(active_key), 32'd7);
    tick(2);
    rst = 1'b1;
    en  = 1'b1;
    tick(3);

    // UP tap for 3 cycles: one pulse, then the timer is dropped on release.
    base = cyc + 1;
    expect_at(base, 0, K_UP);
    key_level = K_UP;
    tick(1);
    check_eq("tap_active", 32'(active_key), 32'd0);
    check_eq("tap_held", 32'(key_held), 32'(K_UP));
    tick(2);
    key_level = '0;
    tick(1);
    check_eq("tap_release_active", 32'(active_key), 32'd7);
    tick(15);

    // DOWN held for 30 cycles: pulses at 0, 10, 14, 18, 22 and 26.
    base = cyc + 1;
    expect_at(base, 0, K_DOWN);
    expect_at(base, 10, K_DOWN);
    expect_at(base, 14, K_DOWN);
    expect_at(base, 18, K_DOWN);
    expect_at(base, 22, K_DOWN);
    expect_at(base, 26, K_DOWN);
    key_level = K_DOWN;
    tick(12);
    check_eq("hold_active", 32'(active_key), 32'd1);
    tick(18);
    key_level = '0;
    tick(1);
    check_eq("hold_release_active", 32'(active_key), 32'd7);
    tick(10);

    // ENTER held for 30 cycles: a single pulse, and it never owns the timer.
    base = cyc + 1;
    expect_at(base, 0, K_ENTER);
    key_level = K_ENTER;
    tick(1);
    check_eq("enter_active", 32'(active_key), 32'd7);
    tick(29);
    key_level = '0;
    tick(10);

    // UP and ENTER rise in the same cycle: only ENTER pulses. UP, held alone afterwards, stays quiet.
    base = cyc + 1;
    expect_at(base, 0, K_ENTER);
    key_level = K_UP | K_ENTER;
    tick(5);
    key_level = K_UP;
    tick(20);
    check_eq("arb_active", 32'(active_key), 32'd7);
    key_level = '0;
    tick(5);

    // LEFT held, so its first repeat at 10 is legitimate. RIGHT pressed at 12 takes over.
    base = cyc + 1;
    expect_at(base, 0, K_LEFT);
    expect_at(base, 10, K_LEFT);
    expect_at(base, 12, K_RIGHT);
    expect_at(base, 22, K_RIGHT);
    expect_at(base, 26, K_RIGHT);
    key_level = K_LEFT;
    tick(12);
    key_level = K_LEFT | K_RIGHT;
    tick(1);
    check_eq("steal_active", 32'(active_key), 32'd3);
    tick(16);
    key_level = '0;
    tick(1);
    check_eq("steal_release_active", 32'(active_key), 32'd7);
    tick(10);

    // en dropped mid-HOLD: the timer is cleared. A key held while en rises does not pulse.
    base = cyc + 1;
    expect_at(base, 0, K_DOWN);
    key_level = K_DOWN;
    tick(3);
    en = 1'b0;
    tick(1);
    check_eq("en_off_active", 32'(active_key), 32'd7);
    check_eq("en_off_held", 32'(key_held), 32'(K_DOWN));
    tick(15);
    en = 1'b1;
    tick(12);
    key_level = '0;
    tick(3);

    // Reset while DOWN repeats, with a pulse high at that moment.
    base = cyc + 1;
    expect_at(base, 0, K_DOWN);
    expect_at(base, 10, K_DOWN);
    expect_at(base, 14, K_DOWN);
    key_level = K_DOWN;
    tick(15);
    rst = 1'b0;
    #1;
    check_eq("async_rst_pulse", 32'(key_pulse), 32'd0);
    check_eq("async_rst_active", 32'(active_key), 32'd7);
    check_eq("async_rst_held", 32'(key_held), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(30);
    check_eq("post_rst_active", 32'(active_key), 32'd7);
    check_eq("post_rst_held", 32'(key_held), 32'(K_DOWN));
    key_level = '0;
    tick(3);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
